// File: rtl/display_scan_ctrl_if.sv
// Bundles the load handshake, display controls and decoder-stage signals of the scan controller.
// master = scan controller side, slave = the block that feeds it and the decoder stage.
`timescale 1ns/1ps

interface display_scan_ctrl_if;
    logic [15:0] digits_in;
    logic        load;
    logic        load_ack;
    logic [3:0]  blink_mask;
    logic        display_on;
    logic [1:0]  s;
    logic [3:0]  num;
    logic        en;
    logic        frame_done;
    logic        blink_phase;

    modport master (
        input  digits_in,
        input  load,
        input  blink_mask,
        input  display_on,
        output load_ack,
        output s,
        output num,
        output en,
        output frame_done,
        output blink_phase
    );

    modport slave (
        output digits_in,
        output load,
        output blink_mask,
        output display_on,
        input  load_ack,
        input  s,
        input  num,
        input  en,
        input  frame_done,
        input  blink_phase
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed HH:MM scan controller with frame-boundary double buffering and per-digit blink.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros of the hours digits.
`timescale 1ns/1ps

module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter int CNT_W       = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    display_scan_ctrl_if.master   bus
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_DIV - 1);

    state_t           state;
    state_t           state_next;
    logic             run;

    logic [CNT_W-1:0] pre_cnt;
    logic [CNT_W-1:0] blink_cnt;
    logic [1:0]       s_q;
    logic [15:0]      shadow;
    logic [15:0]      pend;
    logic             pending;
    logic             load_ack_q;
    logic             frame_done_q;
    logic             blink_phase_q;

    logic             tick;
    logic             boundary;
    logic             commit;
    logic [3:0]       lzb;
    logic [3:0]       num_c;
    logic             en_c;

    // Enable stays off until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        run        = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_RUN;
            ST_RUN:  run        = 1'b1;
            default: state_next = ST_IDLE;
        endcase
    end

    assign tick     = (pre_cnt == REFRESH_LAST);
    assign boundary = tick && (s_q == 2'd3);
    assign commit   = boundary && (pending || bus.load);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt      <= '0;
            s_q          <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + CNT_W'(1);
            frame_done_q <= boundary;
            if (tick) begin
                s_q <= s_q + 2'd1;
            end
        end
    end

    // A load arriving on the boundary cycle itself bypasses pend and commits directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow     <= 16'h0000;
            pend       <= 16'h0000;
            pending    <= 1'b0;
            load_ack_q <= 1'b0;
        end else begin
            load_ack_q <= commit;
            if (boundary) begin
                if (commit) begin
                    shadow <= bus.load ? bus.digits_in : pend;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pend    <= bus.digits_in;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt     <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt     <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    // Hours digits only: a zero tens-of-hours digit, and then a zero hours-units digit, go dark.
    always_comb begin
        lzb = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        lzb[3] = (shadow[15:12] == 4'd0);
        lzb[2] = lzb[3] && (shadow[11:8] == 4'd0);
`endif
    end

    always_comb begin
        num_c = shadow[{s_q, 2'b00} +: 4];
        en_c  = run & bus.display_on & ~(bus.blink_mask[s_q] & blink_phase_q) & ~lzb[s_q];
    end

    assign bus.s           = s_q;
    assign bus.num         = num_c;
    assign bus.en          = en_c;
    assign bus.load_ack    = load_ack_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.blink_phase = blink_phase_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: stimulus pushes expected commits, a monitor checks each ack'd frame.
`timescale 1ns/1ps

module tb_display_scan_ctrl;

    logic clk;
    logic reset;
    int   k;
    int   checks;
    int   errors;
    int   ack_count;

    logic [15:0] exp_q[$];
    logic [15:0] cur_exp;
    int          win;
    logic        win_active;

    display_scan_ctrl_if dif ();

    display_scan_ctrl #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (16),
        .CNT_W       (27)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (k=%0d)", name, actual, expected, k);
        end
    endtask

    task automatic advance_to(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] value, input bit expect_commit);
        dif.digits_in = value;
        dif.load      = 1'b1;
        if (expect_commit) exp_q.push_back(value);
        @(negedge clk);
        k++;
        dif.load      = 1'b0;
        dif.digits_in = 16'hDEAD;
    endtask

    task automatic wait_frame(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            k++;
            cycles++;
        end while (!dif.frame_done && cycles < limit);
    endtask

    // Monitor: every ack must match a queued commit and the following frame must show that value.
    always @(negedge clk) begin
        if (reset && dif.load_ack) begin
            ack_count++;
            check_output("ack_with_frame_done", {15'd0, dif.frame_done}, 16'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack: got ack, expected none (k=%0d)", k);
            end else begin
                cur_exp    = exp_q.pop_front();
                win        = 0;
                win_active = 1'b1;
            end
        end
        if (win_active) begin
            if (win % 4 == 0) begin
                check_output("frame_slot_s", {14'd0, dif.s}, 16'(win / 4));
                check_output("frame_slot_num", {12'd0, dif.num}, {12'd0, cur_exp[4*(win/4) +: 4]});
            end
            win++;
            if (win == 16) win_active = 1'b0;
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cyc;
        logic lz_exp;
        checks        = 0;
        errors        = 0;
        ack_count     = 0;
        k             = 0;
        win           = 0;
        win_active    = 1'b0;
        cur_exp       = 16'h0000;
        reset         = 1'b0;
        dif.digits_in = 16'h0000;
        dif.load      = 1'b0;
        dif.blink_mask = 4'b0000;
        dif.display_on = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        lz_exp = 1'b0;
`else
        lz_exp = 1'b1;
`endif

        // Reset state and first frame timing
        repeat (2) @(negedge clk);
        check_output("reset_s", {14'd0, dif.s}, 16'd0);
        check_output("reset_en", {15'd0, dif.en}, 16'd0);
        check_output("reset_num", {12'd0, dif.num}, 16'd0);
        check_output("reset_frame_done", {15'd0, dif.frame_done}, 16'd0);
        check_output("reset_load_ack", {15'd0, dif.load_ack}, 16'd0);
        check_output("reset_blink_phase", {15'd0, dif.blink_phase}, 16'd0);
        reset = 1'b1;
        k = 0;
        advance_to(1);
        check_output("run_s0", {14'd0, dif.s}, 16'd0);
        check_output("run_en", {15'd0, dif.en}, 16'd1);
        advance_to(3);
        check_output("slot0_hold", {14'd0, dif.s}, 16'd0);
        advance_to(4);
        check_output("slot1_step", {14'd0, dif.s}, 16'd1);
        advance_to(9);
        check_output("slot2_step", {14'd0, dif.s}, 16'd2);
        reset = 1'b0;
        #1;
        check_output("midframe_reset_s", {14'd0, dif.s}, 16'd0);
        check_output("midframe_reset_en", {15'd0, dif.en}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        wait_frame(40, cyc);
        check_output("frame_period_1", 16'(cyc), 16'd16);
        wait_frame(40, cyc);
        check_output("frame_period_2", 16'(cyc), 16'd16);
        advance_to(32);

        // Single load commits only at the boundary
        advance_to(37);
        check_output("pre_load_s", {14'd0, dif.s}, 16'd1);
        apply_stimulus(16'h1234, 1'b1);
        advance_to(47);
        check_output("num_before_boundary", {12'd0, dif.num}, 16'd0);
        check_output("no_frame_done_early", {15'd0, dif.frame_done}, 16'd0);
        advance_to(48);
        check_output("frame_done_at_48", {15'd0, dif.frame_done}, 16'd1);
        check_output("ack_at_48", {15'd0, dif.load_ack}, 16'd1);
        advance_to(64);
        check_output("no_ack_empty_boundary", {15'd0, dif.load_ack}, 16'd0);

        // Latest load wins; load on the boundary cycle commits there
        advance_to(65);
        apply_stimulus(16'h1111, 1'b0);
        advance_to(70);
        apply_stimulus(16'h2222, 1'b1);
        advance_to(95);
        apply_stimulus(16'h5678, 1'b1);
        check_output("boundary_load_ack", {15'd0, dif.load_ack}, 16'd1);
        check_output("boundary_load_num", {12'd0, dif.num}, 16'd8);

        // Blinking and display_on
        dif.blink_mask = 4'b1100;
        advance_to(97);
        check_output("blink_off_s0_en", {15'd0, dif.en}, 16'd1);
        advance_to(105);
        check_output("blink_off_s2_en", {15'd0, dif.en}, 16'd1);
        advance_to(111);
        check_output("blink_phase_before", {15'd0, dif.blink_phase}, 16'd0);
        advance_to(112);
        check_output("blink_phase_after", {15'd0, dif.blink_phase}, 16'd1);
        advance_to(113);
        check_output("blink_on_s0_en", {15'd0, dif.en}, 16'd1);
        advance_to(117);
        check_output("blink_on_s1_en", {15'd0, dif.en}, 16'd1);
        advance_to(121);
        check_output("blink_on_s2_en", {15'd0, dif.en}, 16'd0);
        advance_to(125);
        check_output("blink_on_s3_en", {15'd0, dif.en}, 16'd0);
        advance_to(128);
        check_output("blink_phase_back", {15'd0, dif.blink_phase}, 16'd0);
        dif.display_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            advance_to(129 + 4 * i);
            check_output("dark_en", {15'd0, dif.en}, 16'd0);
            check_output("dark_s", {14'd0, dif.s}, 16'(i));
        end
        advance_to(144);
        dif.display_on = 1'b1;
        dif.blink_mask = 4'b0000;

        // Leading-zero blanking of the hours digits
        advance_to(145);
        apply_stimulus(16'h0059, 1'b1);
        advance_to(161);
        check_output("lzb_0059_s0", {15'd0, dif.en}, 16'd1);
        advance_to(162);
        apply_stimulus(16'h0159, 1'b1);
        advance_to(169);
        check_output("lzb_0059_s2", {15'd0, dif.en}, {15'd0, lz_exp});
        advance_to(173);
        check_output("lzb_0059_s3", {15'd0, dif.en}, {15'd0, lz_exp});
        advance_to(177);
        check_output("lzb_0159_s0", {15'd0, dif.en}, 16'd1);
        advance_to(185);
        check_output("lzb_0159_s2", {15'd0, dif.en}, 16'd1);
        advance_to(189);
        check_output("lzb_0159_s3", {15'd0, dif.en}, {15'd0, lz_exp});
        advance_to(192);

        check_output("commits_outstanding", 16'(exp_q.size()), 16'd0);
        check_output("ack_count", 16'(ack_count), 16'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
